// File: rtl/imm_enc_pkg.sv
// ============================================================================
// Module : imm_enc_pkg
// Brief  : Shared types and immediate-range constants for the immediate encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imm_enc_pkg;

    typedef enum logic [1:0] {
        IMM_R = 2'b00,
        IMM_I = 2'b01,
        IMM_S = 2'b10,
        IMM_B = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENC   = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;

    typedef struct packed {
        imm_src_t    src;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } bundle_t;

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// ============================================================================
// Module : imm_pack
// Brief  : Combinational RV32I field packer with immediate range flag.
//          Range checking enabled by macro IMM_ENC_RANGE_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_pack
    import imm_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            imm_src,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [6:0]            funct7,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  range_ok
);

    always_comb begin
        word = '0;
        case (imm_src_t'(imm_src))
            IMM_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            IMM_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        endcase
    end

`ifdef IMM_ENC_RANGE_CHECK_EN
    logic signed [DATA_WIDTH-1:0] w_imm_s;
    assign w_imm_s = $signed(imm);

    always_comb begin
        range_ok = 1'b1;
        case (imm_src_t'(imm_src))
            IMM_I, IMM_S: range_ok = (w_imm_s >= IMM12_MIN) && (w_imm_s <= IMM12_MAX);
            IMM_B:        range_ok = (w_imm_s >= IMM13_MIN) && (w_imm_s <= IMM13_MAX) && !imm[0];
            default:      range_ok = 1'b1;
        endcase
    end
`else
    // High immediate bits are deliberately truncated when checking is off.
    logic w_unused_imm;
    assign w_unused_imm = ^imm[DATA_WIDTH-1:13];
    assign range_ok     = 1'b1;
`endif

endmodule

`default_nettype wire

// File: rtl/imm_encoder_loader.sv
// ============================================================================
// Module : imm_encoder_loader
// Brief  : Encodes instruction field bundles and writes them sequentially into
//          instruction memory. Optional macro: IMM_ENC_RANGE_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_encoder_loader
    import imm_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            imm_src,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [6:0]            funct7,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-2:0] word_count,
    output logic                  full,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] C_LAST = ~ADDR_WIDTH'(3);

    state_t                r_state;
    bundle_t               r_bundle;
    logic                  r_clear_pend;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [ADDR_WIDTH-2:0] r_count;
    logic                  r_full;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_range_ok;
    logic                  w_clr;

    imm_pack #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pack (
        .imm_src  (r_bundle.src),
        .opcode   (r_bundle.opcode),
        .rd       (r_bundle.rd),
        .funct3   (r_bundle.funct3),
        .rs1      (r_bundle.rs1),
        .rs2      (r_bundle.rs2),
        .funct7   (r_bundle.funct7),
        .imm      (r_bundle.imm),
        .word     (w_word),
        .range_ok (w_range_ok)
    );

    // A clear seen during ENC/WRITE is held until the bundle retires.
    assign w_clr    = clear || r_clear_pend;
    assign in_ready = rst_n && (r_state == IDLE) && !r_full && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bundle     <= '0;
            r_clear_pend <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= C_BASE;
            r_mem_wdata  <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_we     <= 1'b0;
                    r_clear_pend <= 1'b0;
                    if (clear) begin
                        r_mem_addr <= C_BASE;
                        r_count    <= '0;
                        r_full     <= 1'b0;
                        r_err      <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        r_bundle <= '{src: imm_src_t'(imm_src), opcode: opcode, rd: rd,
                                      funct3: funct3, rs1: rs1, rs2: rs2,
                                      funct7: funct7, imm: imm};
                        r_state  <= ENC;
                    end
                end
                ENC: begin
                    if (clear) begin
                        r_clear_pend <= 1'b1;
                    end
                    if (!w_range_ok) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                        if (w_clr) begin
                            r_mem_addr <= C_BASE;
                            r_count    <= '0;
                            r_full     <= 1'b0;
                            r_err      <= 1'b0;
                        end
                    end else begin
                        r_mem_wdata <= w_word;
                        r_mem_we    <= 1'b1;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    r_mem_we     <= 1'b0;
                    r_clear_pend <= 1'b0;
                    r_state      <= IDLE;
                    if (w_clr) begin
                        r_mem_addr <= C_BASE;
                        r_count    <= '0;
                        r_full     <= 1'b0;
                        r_err      <= 1'b0;
                    end else begin
                        r_count <= r_count + (ADDR_WIDTH-1)'(1);
                        if (r_mem_addr == C_LAST) begin
                            r_full <= 1'b1;
                        end else begin
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_count;
    assign full       = r_full;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder_loader.sv
// ============================================================================
// Module : tb_imm_encoder_loader
// Brief  : Randomized scoreboard bench for imm_encoder_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder_loader;

    localparam int AW        = 8;
    localparam int LAST_ADDR = (1 << AW) - 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  imm_src = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [AW-2:0] word_count;
    logic        full;
    logic        err;

    always #5 clk = ~clk;

    imm_encoder_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_src    (imm_src),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct7     (funct7),
        .imm        (imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .full       (full),
        .err        (err)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sbq[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_addr = 0;
    int          exp_count = 0;
    bit          exp_full = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] last_wdata = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference encoding built from bit weights of each RV32I field.
    function automatic logic [31:0] model_enc(int s, int op, int rdv, int f3, int r1, int r2,
                                              int f7, int im);
        int base;
        base = (r1 << 15) + (f3 << 12) + op;
        case (s)
            0: return 32'((f7 << 25) + (r2 << 20) + base + (rdv << 7));
            1: return 32'(((im & 'hFFF) << 20) + base + (rdv << 7));
            2: return 32'((((im >> 5) & 'h7F) << 25) + (r2 << 20) + base + ((im & 'h1F) << 7));
            default: return 32'((((im >> 12) & 1) << 31) + (((im >> 5) & 'h3F) << 25) +
                                (r2 << 20) + base + (((im >> 1) & 'hF) << 8) +
                                (((im >> 11) & 1) << 7));
        endcase
    endfunction

    function automatic bit model_ok(int s, int im);
`ifdef IMM_ENC_RANGE_CHECK_EN
        if (s == 1 || s == 2) return (im >= -2048) && (im <= 2047);
        if (s == 3) return (im >= -4096) && (im <= 4094) && (im % 2 == 0);
        return 1'b1;
`else
        return (s >= 0) || (im != im);
`endif
    endfunction

    function automatic void model_clear();
        exp_addr  = 0;
        exp_count = 0;
        exp_full  = 1'b0;
        exp_err   = 1'b0;
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_we === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("spurious_we", 32'(mem_we), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", mem_wdata, e.data);
                    last_wdata = mem_wdata;
                end
            end
        end
    end

    task automatic check_state(string tag);
        check({tag, "_addr"},  32'(mem_addr),   32'(exp_addr));
        check({tag, "_count"}, 32'(word_count), 32'(exp_count));
        check({tag, "_full"},  32'(full),       32'(exp_full));
        check({tag, "_err"},   32'(err),        32'(exp_err));
    endtask

    task automatic drive(int s, int op, int rdv, int f3, int r1, int r2, int f7, int im);
        imm_src = 2'(s);
        opcode  = 7'(op);
        rd      = 5'(rdv);
        funct3  = 3'(f3);
        rs1     = 5'(r1);
        rs2     = 5'(r2);
        funct7  = 7'(f7);
        imm     = 32'(im);
    endtask

    task automatic send(int s, int op, int rdv, int f3, int r1, int r2, int f7, int im,
                        bit clr_in_enc, bit use_exp, logic [31:0] exp_word);
        int          n;
        bit          good;
        logic [31:0] w;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        drive(s, op, rdv, f3, r1, r2, f7, im);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        good = model_ok(s, im);
        w    = use_exp ? exp_word : model_enc(s, op, rdv, f3, r1, r2, f7, im);
        if (good) sbq.push_back('{addr: exp_addr, data: w});
        @(negedge clk);
        check("we_in_enc", 32'(mem_we), 32'd0);
        check("ready_busy", 32'(in_ready), 32'd0);
        if (clr_in_enc) clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("we_latency", 32'(mem_we), 32'(good));
        if (clr_in_enc) begin
            model_clear();
        end else if (good) begin
            exp_count++;
            if (exp_addr == LAST_ADDR) exp_full = 1'b1;
            else exp_addr += 4;
        end else begin
            exp_err = 1'b1;
        end
        @(negedge clk);
        check_state("post");
    endtask

    task automatic send_random();
        int im;
        if ($urandom_range(0, 7) == 0) im = int'($urandom);
        else im = int'($urandom_range(0, 8191)) - 4096;
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 127)), im, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] x;
        int          bimm;
        int          n;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we",    32'(mem_we),   32'd0);
        check("rst_wdata", mem_wdata,     32'd0);
        check_state("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);

        send(1, 'h13, 1, 0, 0, 0, 0, -1, 1'b0, 1'b1, 32'hFFF00093);
        send(3, 'h63, 0, 0, 1, 2, 0, -8, 1'b0, 1'b1, 32'hFE208CE3);
        x    = last_wdata;
        bimm = $signed({{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0});
        check("b_reextract", 32'(bimm), 32'hFFFFFFF8);

        send(1, 'h13, 3, 0, 2, 0, 0, 2048, 1'b0, 1'b0, 32'd0);
        send(2, 'h23, 0, 2, 5, 6, 0, -2049, 1'b0, 1'b0, 32'd0);
        send(3, 'h63, 0, 1, 3, 4, 0, 4095, 1'b0, 1'b0, 32'd0);
        send(0, 'h33, 7, 0, 8, 9, 'h20, 12345, 1'b0, 1'b0, 32'd0);

        // Clear during ENC: word still lands at the current address.
        send(1, 'h13, 4, 0, 4, 0, 0, 100, 1'b1, 1'b0, 32'd0);

        // Clear together with valid: no capture.
        @(negedge clk);
        drive(1, 'h13, 1, 0, 0, 0, 0, 5);
        clear    = 1'b1;
        in_valid = 1'b1;
        #1 check("clr_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_state("clr_valid");

        repeat (40) send_random();

        // Reset asserted while WRITE is on the bus.
        @(negedge clk);
        drive(1, 'h13, 2, 0, 1, 0, 0, 7);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        sbq.push_back('{addr: exp_addr, data: model_enc(1, 'h13, 2, 0, 1, 0, 0, 7)});
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_we_drop", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_state("rst_mid");

        n = 0;
        while (!exp_full && n < 200) begin
            send_random();
            n++;
        end
        check("full_reached", 32'(exp_full), 32'(full));
        @(negedge clk);
        drive(1, 'h13, 1, 0, 0, 0, 0, 1);
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check_state("full");
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_encoder_loader.md
Name: imm_encoder_loader

Overview:
- Inverse of the control unit's immediate extraction: takes decoded instruction fields plus a full-width signed immediate, and scatters the immediate into RV32I bit positions.
- Writes each resulting 32-bit word sequentially into instruction memory.
- Used by the bench/boot path to load programs into the single-cycle CPU's instruction memory without a pre-assembled hex file.
- Sequential: valid/ready input handshake, 3-state FSM, word-address counter with full detection.

Parameters:
- DATA_WIDTH, 32, instruction/immediate width (only 32 is supported).
- ADDR_WIDTH, 8, byte-address width of instruction memory.
- BASE_ADDR, 0, first byte address written after reset/clear (must be a multiple of 4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous; returns address to BASE_ADDR, clears err and count.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- imm_src  in  2  format; same encoding as the ImmSrc control field: 00 R (no immediate), 01 I, 10 S, 11 B.
- opcode  in  7  instr[6:0].
- rd  in  5  instr[11:7]; ignored for S/B.
- funct3  in  3  instr[14:12].
- rs1  in  5  instr[19:15].
- rs2  in  5  instr[24:20]; ignored for I.
- funct7  in  7  instr[31:25]; used for R only.
- imm  in  DATA_WIDTH  signed immediate (byte offset for B).
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  byte address of current write.
- mem_wdata  out  DATA_WIDTH  encoded instruction.
- word_count  out  ADDR_WIDTH-1  words written since reset/clear.
- full  out  1  last word address has been written.
- err  out  1  sticky range error.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=0 during reset.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, full=0, err=0.
  - rst_n low mid-operation drops mem_we immediately; any captured bundle is discarded.
- FSM states:
  - IDLE: in_ready = !full && !clear. in_valid&&in_ready captures the bundle -> ENC.
  - ENC: build the word into mem_wdata.
    - Range fail (with check enabled) -> set err, no write -> IDLE.
    - Otherwise -> WRITE.
  - WRITE: mem_we=1 for exactly this cycle.
    - Next edge: mem_addr += 4 and word_count += 1.
    - If mem_addr was the last word address (2^ADDR_WIDTH-4), set full and hold mem_addr (no wrap).
    - -> IDLE.
- Latency and throughput:
  - Handshake at edge N -> mem_we high in cycle N+2.
  - One word per 3 cycles; in_ready=0 in ENC/WRITE.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Range rules:
  - I/S: imm must lie in -2048..2047.
  - B: imm must lie in -4096..4094 and imm[0]=0.
  - R: imm ignored.
- clear:
  - In IDLE: applies next edge.
  - In ENC/WRITE: pending write still completes, then address/count/err/full reset.
  - clear and in_valid together: clear wins, no capture.
- err: sticky until reset or clear; does not block further accepts.

Optional Feature:
- Macro: IMM_ENC_RANGE_CHECK_EN.
- Defined: range rules enforced; failing bundle sets err and is dropped (no mem_we).
- Undefined: no check. Immediate silently truncated to field bits; B imm[0] ignored; err tied 0. ENC always -> WRITE.

Decomposition:
- Shared package imm_enc_pkg:
  - imm_src_t enum (IMM_R=2'b00, IMM_I=2'b01, IMM_S=2'b10, IMM_B=2'b11), reused by the control unit.
  - state_t enum {IDLE, ENC, WRITE}.
  - Constants IMM12_MIN/MAX and IMM13_MIN/MAX.
- One natural sub-module: imm_pack, a combinational field-to-word packer plus range-ok flag. The FSM/counter stays in the top module.

Test Plan:
- I-type: addi opcode 0010011, rd=1, rs1=0, funct3=0, imm=-1 -> mem_we at cycle N+2, mem_addr=0, mem_wdata=0xFFF00093.
- B-type: beq opcode 1100011, rs1=1, rs2=2, imm=-8 -> mem_wdata=0xFE208CE3. Result re-extracted by the CPU's B-immediate path equals -8.
- Range: I imm=2048 with macro defined -> err=1, no mem_we, mem_addr unchanged. Without macro -> word written with imm field 0x800.
- Full: ADDR_WIDTH=4, five I bundles -> writes at 0,4,8,12; full=1 after fourth; in_ready stays 0; fifth never accepted.
- Reset mid-operation: rst_n low during WRITE -> mem_we falls at once; after release mem_addr=0 and word_count=0.
- clear during ENC: word still written at current address; one cycle after WRITE, mem_addr=BASE_ADDR and word_count=0.
